// File: rtl/pwr_seq_pkg.sv
`default_nettype none
// ============================================================================
// pwr_seq_pkg : shared state encoding and width helpers for the rail sequencer
// Rev 1.0
// ============================================================================
package pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_UP_WAIT   = 3'd1,
    ST_UP_SETTLE = 3'd2,
    ST_ON        = 3'd3,
    ST_DN_SETTLE = 3'd4,
    ST_FAULT     = 3'd5
  } pwr_seq_state_e;

  // Counter must hold both the timeout limit and the settle reload value.
  function automatic int cnt_width(input int timeout_cyc, input int settle_cyc);
    int max_cyc;
    max_cyc = (timeout_cyc > settle_cyc) ? timeout_cyc : settle_cyc;
    return $clog2(max_cyc + 1);
  endfunction

  function automatic int idx_width(input int n_rails);
    return (n_rails > 1) ? $clog2(n_rails) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwr_pgood_sync.sv
`default_nettype none
// ============================================================================
// pwr_pgood_sync : N-bit multi-flop synchronizer for asynchronous power-good
// Rev 1.0
// ============================================================================
module pwr_pgood_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pwr_rail_sequencer.sv
`default_nettype none
// ============================================================================
// pwr_rail_sequencer : ordered rail power-up/power-down with pgood fault monitor
// Rev 1.0
// ============================================================================
module pwr_rail_sequencer
  import pwr_seq_pkg::*;
#(
  parameter int N_RAILS     = 8,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pwr_up_req_i,
  input  logic                       pwr_dn_req_i,
  input  logic                       fault_clr_i,
  input  logic [N_RAILS-1:0]         pgood_i,
  output logic [N_RAILS-1:0]         rail_en_o,
  output logic                       busy_o,
  output logic                       all_on_o,
  output logic                       fault_o,
  output logic [$clog2(N_RAILS)-1:0] fault_rail_o,
  output logic                       fault_timeout_o,
  output logic                       seq_done_o
);

  localparam int c_cnt_w = cnt_width(TIMEOUT_CYC, SETTLE_CYC);
  localparam int c_idx_w = idx_width(N_RAILS);

  localparam logic [c_cnt_w-1:0] c_settle_load  = c_cnt_w'(SETTLE_CYC);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);
  localparam logic [c_idx_w-1:0] c_last_idx     = c_idx_w'(N_RAILS - 1);

  pwr_seq_state_e     state_q, state_d;
  logic [c_idx_w-1:0] idx_q, idx_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [N_RAILS-1:0] rail_en_q, rail_en_d;
  logic [c_idx_w-1:0] fault_rail_q, fault_rail_d;
  logic               fault_to_q, fault_to_d;
  logic               seq_done_q, seq_done_d;

  logic [N_RAILS-1:0] pg_s;
  logic [N_RAILS-1:0] w_checked;
  logic               w_monitor;
  logic               w_drop;
  logic [c_idx_w-1:0] w_drop_idx;
  logic               w_settled;

  pwr_pgood_sync #(
    .WIDTH       (N_RAILS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pgood_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (pgood_i),
    .sync_o  (pg_s)
  );

  // Rails below idx are already up; rail idx counts only once its pgood has been seen.
  always_comb begin
    w_monitor  = (state_q == ST_UP_WAIT) || (state_q == ST_UP_SETTLE) || (state_q == ST_ON);
    w_checked  = '0;
    w_drop_idx = '0;
    for (int i = 0; i < N_RAILS; i++) begin
      w_checked[i] = w_monitor && ((i < int'(idx_q)) ||
                                   ((i == int'(idx_q)) && (state_q != ST_UP_WAIT)));
    end
    for (int i = N_RAILS - 1; i >= 0; i--) begin
      if (w_checked[i] && !pg_s[i]) w_drop_idx = c_idx_w'(i);
    end
    w_drop    = |(w_checked & ~pg_s);
    w_settled = (cnt_q <= c_cnt_one);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    rail_en_d    = rail_en_q;
    fault_rail_d = fault_rail_q;
    fault_to_d   = fault_to_q;
    seq_done_d   = 1'b0;

    if (w_drop) begin
      state_d      = ST_FAULT;
      rail_en_d    = '0;
      fault_rail_d = w_drop_idx;
      fault_to_d   = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (pwr_up_req_i) begin
            state_d      = ST_UP_WAIT;
            idx_d        = '0;
            cnt_d        = '0;
            rail_en_d    = '0;
            rail_en_d[0] = 1'b1;
          end
        end
        ST_UP_WAIT: begin
          if (!pg_s[idx_q] && (cnt_q == c_timeout_last)) begin
            state_d      = ST_FAULT;
            rail_en_d    = '0;
            fault_rail_d = idx_q;
            fault_to_d   = 1'b1;
          end else if (pwr_dn_req_i) begin
            state_d          = ST_DN_SETTLE;
            rail_en_d[idx_q] = 1'b0;
            cnt_d            = c_settle_load;
          end else if (pg_s[idx_q]) begin
            state_d = ST_UP_SETTLE;
            cnt_d   = c_settle_load;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_UP_SETTLE: begin
          if (pwr_dn_req_i) begin
            state_d          = ST_DN_SETTLE;
            rail_en_d[idx_q] = 1'b0;
            cnt_d            = c_settle_load;
          end else if (w_settled) begin
            cnt_d = '0;
            if (idx_q == c_last_idx) begin
              state_d    = ST_ON;
              seq_done_d = 1'b1;
            end else begin
              state_d                 = ST_UP_WAIT;
              idx_d                   = idx_q + 1'b1;
              rail_en_d[idx_q + 1'b1] = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_ON: begin
          if (pwr_dn_req_i) begin
            state_d               = ST_DN_SETTLE;
            idx_d                 = c_last_idx;
            rail_en_d[c_last_idx] = 1'b0;
            cnt_d                 = c_settle_load;
          end
        end
        ST_DN_SETTLE: begin
          if (w_settled) begin
            if (idx_q == '0) begin
              state_d    = ST_OFF;
              cnt_d      = '0;
              seq_done_d = 1'b1;
            end else begin
              idx_d                   = idx_q - 1'b1;
              rail_en_d[idx_q - 1'b1] = 1'b0;
              cnt_d                   = c_settle_load;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_FAULT: begin
          if (fault_clr_i) begin
            state_d      = ST_OFF;
            idx_d        = '0;
            cnt_d        = '0;
            fault_rail_d = '0;
            fault_to_d   = 1'b0;
          end
        end
        default: begin
          state_d   = ST_OFF;
          rail_en_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_OFF;
      idx_q        <= '0;
      cnt_q        <= '0;
      rail_en_q    <= '0;
      fault_rail_q <= '0;
      fault_to_q   <= 1'b0;
      seq_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      rail_en_q    <= rail_en_d;
      fault_rail_q <= fault_rail_d;
      fault_to_q   <= fault_to_d;
      seq_done_q   <= seq_done_d;
    end
  end

  assign rail_en_o       = rail_en_q;
  assign busy_o          = (state_q == ST_UP_WAIT) || (state_q == ST_UP_SETTLE) ||
                           (state_q == ST_DN_SETTLE);
  assign all_on_o        = (state_q == ST_ON);
  assign fault_o         = (state_q == ST_FAULT);
  assign fault_rail_o    = fault_rail_q;
  assign fault_timeout_o = fault_to_q;
  assign seq_done_o      = seq_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pwr_rail_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pwr_rail_sequencer : scenario bench with a rail_en transition scoreboard
// Rev 1.0
// ============================================================================
module tb_pwr_rail_sequencer;

  localparam int N = 4;

  logic         clk        = 1'b0;
  logic         rst        = 1'b1;
  logic         pwr_up_req = 1'b0;
  logic         pwr_dn_req = 1'b0;
  logic         fault_clr  = 1'b0;
  logic [N-1:0] pg_kill    = '0;
  logic [N-1:0] pg_d1, pg_d2;
  logic [N-1:0] pgood;
  logic [N-1:0] rail_en;
  logic         busy, all_on, fault, fault_timeout, seq_done;
  logic [1:0]   fault_rail;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0] val;
    int           gap;
  } rail_ev_t;
  rail_ev_t exp_q[$];

  pwr_rail_sequencer #(
    .N_RAILS     (N),
    .SETTLE_CYC  (4),
    .TIMEOUT_CYC (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pwr_up_req_i    (pwr_up_req),
    .pwr_dn_req_i    (pwr_dn_req),
    .fault_clr_i     (fault_clr),
    .pgood_i         (pgood),
    .rail_en_o       (rail_en),
    .busy_o          (busy),
    .all_on_o        (all_on),
    .fault_o         (fault),
    .fault_rail_o    (fault_rail),
    .fault_timeout_o (fault_timeout),
    .seq_done_o      (seq_done)
  );

  always #5 clk = ~clk;

  // Rail model: pgood follows rail_en through two flops, so the synchronizer samples it on the third edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pg_d1 <= '0;
      pg_d2 <= '0;
    end else begin
      pg_d1 <= rail_en;
      pg_d2 <= pg_d1;
    end
  end
  assign pgood = pg_d2 & ~pg_kill;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic void push_ev(input logic [N-1:0] v, input int g);
    rail_ev_t ev;
    ev.val = v;
    ev.gap = g;
    exp_q.push_back(ev);
  endfunction

  // Pops one expected event per rail_en change; request inputs act as one-cycle pulses.
  task automatic watch_rail(input string name, input int budget);
    logic [N-1:0] prev;
    int           t_last;
    int           n;
    rail_ev_t     ev;
    prev   = rail_en;
    t_last = cyc;
    n      = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
      pwr_up_req = 1'b0;
      pwr_dn_req = 1'b0;
      if (rail_en !== prev) begin
        ev = exp_q.pop_front();
        n_vec++;
        if (rail_en !== ev.val || (cyc - t_last) != ev.gap) begin
          n_err++;
          $display("FAIL %s: rail_en=%b after %0d cycles, expected %b after %0d cycles",
                   name, rail_en, cyc - t_last, ev.val, ev.gap);
        end
        prev   = rail_en;
        t_last = cyc;
      end
    end
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s: rail_en stuck at %b, expected %b within %0d cycles",
               name, rail_en, ev.val, budget);
    end
  endtask

  task automatic test_reset();
    idle(3);
    n_vec++;
    if ({rail_en, busy, all_on, fault, fault_rail, fault_timeout, seq_done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rail_en=%b busy=%b all_on=%b fault=%b rail=%0d to=%b done=%b, expected all 0",
               rail_en, busy, all_on, fault, fault_rail, fault_timeout, seq_done);
    end
    rst = 1'b0;
    idle(2);
    n_vec++;
    if ({rail_en, busy, all_on, fault} !== '0) begin
      n_err++;
      $display("FAIL reset_release: rail_en=%b busy=%b all_on=%b fault=%b, expected 0",
               rail_en, busy, all_on, fault);
    end
  endtask

  task automatic test_normal_up();
    int   t_last, sd_cnt, sd_at, on_at;
    logic f_seen;
    idle(8);
    push_ev(4'b0001, 1);
    push_ev(4'b0011, 9);
    push_ev(4'b0111, 9);
    push_ev(4'b1111, 9);
    pwr_up_req = 1'b1;
    watch_rail("up_ramp", 60);
    t_last = cyc;
    sd_cnt = 0;
    sd_at  = -1;
    on_at  = -1;
    f_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (seq_done === 1'b1) begin
        sd_cnt++;
        sd_at = cyc - t_last;
      end
      if (all_on === 1'b1 && on_at < 0) on_at = cyc - t_last;
      if (fault !== 1'b0) f_seen = 1'b1;
    end
    n_vec++;
    if (sd_cnt != 1 || sd_at != 9) begin
      n_err++;
      $display("FAIL up_seq_done: %0d pulses, last at +%0d, expected 1 pulse at +9", sd_cnt, sd_at);
    end
    n_vec++;
    if (on_at != 9) begin
      n_err++;
      $display("FAIL up_all_on: all_on rose at +%0d, expected +9", on_at);
    end
    n_vec++;
    if (f_seen !== 1'b0 || busy !== 1'b0 || all_on !== 1'b1 || rail_en !== 4'b1111) begin
      n_err++;
      $display("FAIL up_steady: fault_seen=%b busy=%b all_on=%b rail_en=%b, expected 0 0 1 1111",
               f_seen, busy, all_on, rail_en);
    end
  endtask

  task automatic test_normal_down();
    int t_last, sd_cnt, sd_at;
    push_ev(4'b0111, 1);
    push_ev(4'b0011, 4);
    push_ev(4'b0001, 4);
    push_ev(4'b0000, 4);
    pwr_dn_req = 1'b1;
    watch_rail("down_ramp", 40);
    n_vec++;
    if (busy !== 1'b1 || all_on !== 1'b0) begin
      n_err++;
      $display("FAIL down_busy: busy=%b all_on=%b, expected 1 0", busy, all_on);
    end
    t_last = cyc;
    sd_cnt = 0;
    sd_at  = -1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (seq_done === 1'b1) begin
        sd_cnt++;
        sd_at = cyc - t_last;
      end
    end
    n_vec++;
    if (sd_cnt != 1 || sd_at != 4 || busy !== 1'b0 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL down_done: %0d pulses at +%0d busy=%b fault=%b, expected 1 pulse at +4 busy=0 fault=0",
               sd_cnt, sd_at, busy, fault);
    end
  endtask

  task automatic test_timeout();
    idle(8);
    pg_kill = 4'b0100;
    push_ev(4'b0001, 1);
    push_ev(4'b0011, 9);
    push_ev(4'b0111, 9);
    push_ev(4'b0000, 16);
    pwr_up_req = 1'b1;
    watch_rail("timeout_ramp", 80);
    n_vec++;
    if (fault !== 1'b1 || fault_rail !== 2'd2 || fault_timeout !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_fault: fault=%b rail=%0d to=%b busy=%b, expected 1 2 1 0",
               fault, fault_rail, fault_timeout, busy);
    end
    idle(3);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    n_vec++;
    if ({fault, fault_rail, fault_timeout, seq_done, busy, rail_en} !== '0) begin
      n_err++;
      $display("FAIL timeout_clear: fault=%b rail=%0d to=%b done=%b busy=%b rail_en=%b, expected all 0",
               fault, fault_rail, fault_timeout, seq_done, busy, rail_en);
    end
    pg_kill = '0;
  endtask

  task automatic test_drop_in_on();
    idle(3);
    pg_kill = 4'b0010;
    push_ev(4'b0000, 3);
    watch_rail("drop_on", 10);
    pg_kill = '0;
    n_vec++;
    if (fault !== 1'b1 || fault_rail !== 2'd1 || fault_timeout !== 1'b0 || all_on !== 1'b0) begin
      n_err++;
      $display("FAIL drop_fault: fault=%b rail=%0d to=%b all_on=%b, expected 1 1 0 0",
               fault, fault_rail, fault_timeout, all_on);
    end
    pwr_up_req = 1'b1;
    idle(5);
    n_vec++;
    if (rail_en !== 4'b0000 || fault !== 1'b1 || busy !== 1'b0 || fault_rail !== 2'd1) begin
      n_err++;
      $display("FAIL drop_ignore_req: rail_en=%b fault=%b busy=%b rail=%0d, expected 0000 1 0 1",
               rail_en, fault, busy, fault_rail);
    end
    pwr_up_req = 1'b0;
    fault_clr  = 1'b1;
    tick();
    fault_clr = 1'b0;
    n_vec++;
    if ({fault, fault_rail, fault_timeout, seq_done, rail_en} !== '0) begin
      n_err++;
      $display("FAIL drop_clear: fault=%b rail=%0d to=%b done=%b rail_en=%b, expected all 0",
               fault, fault_rail, fault_timeout, seq_done, rail_en);
    end
  endtask

  task automatic test_abort_ramp();
    int t_last, sd_cnt, sd_at;
    idle(8);
    push_ev(4'b0001, 1);
    push_ev(4'b0011, 9);
    pwr_up_req = 1'b1;
    watch_rail("abort_pre", 30);
    idle(6);
    push_ev(4'b0001, 1);
    push_ev(4'b0000, 4);
    pwr_dn_req = 1'b1;
    watch_rail("abort_down", 20);
    t_last = cyc;
    sd_cnt = 0;
    sd_at  = -1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (seq_done === 1'b1) begin
        sd_cnt++;
        sd_at = cyc - t_last;
      end
    end
    n_vec++;
    if (sd_cnt != 1 || sd_at != 4 || busy !== 1'b0 || fault !== 1'b0 || rail_en !== 4'b0000) begin
      n_err++;
      $display("FAIL abort_done: %0d pulses at +%0d busy=%b fault=%b rail_en=%b, expected 1 at +4 0 0 0000",
               sd_cnt, sd_at, busy, fault, rail_en);
    end
  endtask

  task automatic test_reset_mid_ramp();
    idle(8);
    push_ev(4'b0001, 1);
    push_ev(4'b0011, 9);
    push_ev(4'b0111, 9);
    pwr_up_req = 1'b1;
    watch_rail("rst_ramp", 40);
    idle(2);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre_busy: busy=%b, expected 1", busy);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if ({rail_en, busy, all_on, fault, fault_rail, fault_timeout, seq_done} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_ramp: rail_en=%b busy=%b all_on=%b fault=%b rail=%0d to=%b done=%b, expected all 0",
               rail_en, busy, all_on, fault, fault_rail, fault_timeout, seq_done);
    end
    rst = 1'b0;
    idle(3);
    n_vec++;
    if (rail_en !== 4'b0000 || busy !== 1'b0 || seq_done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_stays_off: rail_en=%b busy=%b done=%b, expected 0000 0 0", rail_en, busy, seq_done);
    end
  endtask

  initial begin
    test_reset();
    test_normal_up();
    test_normal_down();
    test_timeout();
    test_normal_up();
    test_drop_in_on();
    test_abort_ramp();
    test_reset_mid_ramp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors so far", n_vec);
    $fatal(1);
  end

endmodule
`default_nettype wire
